// File: rtl/mem_io_pkg.sv
// Shared constants for the memory/IO responder: IO window location, status
// register layout and default RAM sizing.
package mem_io_pkg;

    localparam int          DEFAULT_ADDR_WIDTH = 17;
    localparam logic [31:0] DEFAULT_IO_ADDR    = 32'h0003_0000;
    localparam logic [31:0] STATUS_OFFSET      = 32'd4;

    // Status register bit positions
    localparam int STAT_FULL = 0;
    localparam int STAT_RX   = 1;
    localparam int STAT_OVF  = 2;

endpackage

// File: rtl/io_tx_fifo.sv
// Synchronous byte FIFO feeding the host TX stream.
// Ports:
//   clk_in, rst_n_in  clock, async active-low reset (pointers/count only)
//   push, push_data   enqueue request; accepted when not full or popping
//   pop               dequeue request; ignored when empty
//   count             current occupancy (0..DEPTH)
//   count_nxt         occupancy after this edge, for registered flags
//   head_data         entry at the head
module io_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = 3
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [PTR_WIDTH:0]    count,
    output logic [PTR_WIDTH:0]    count_nxt,
    output logic [DATA_WIDTH-1:0] head_data
);

    localparam int CW = PTR_WIDTH + 1;
    localparam logic [PTR_WIDTH:0] FULL_C = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] store [DEPTH];
    logic [PTR_WIDTH-1:0]  head;
    logic [PTR_WIDTH-1:0]  tail;
    logic                  push_ok;
    logic                  pop_ok;

    assign pop_ok  = pop && (count != '0);
    // A pop in the same cycle frees a slot, so a push at full still lands.
    assign push_ok = push && ((count != FULL_C) || pop_ok);

    assign head_data = store[head];

    always_comb begin
        count_nxt = count;
        case ({push_ok, pop_ok})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (push_ok) store[tail] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_ok) tail <= tail + 1'b1;
            if (pop_ok)  head <= head + 1'b1;
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// Memory-side responder for the CPU byte bus: byte RAM with 1-cycle reads,
// plus an IO window holding a TX FIFO toward the host and an RX holding byte.
// Optional feature macro: IO_STATUS_REG_EN adds a status register at
// IO_ADDR+4 ({5'b0, overflow, rx_full, io_buffer_full}); writes there clear
// the sticky overflow. Without it IO_ADDR+4 is ordinary RAM.
// Ports:
//   clk_in, rst_n_in           clock, async active-low reset
//   rdy_in                     CPU access enable
//   mem_a, mem_dout, mem_wr    CPU address, write data, write strobe
//   mem_din                    registered read data
//   io_tx_valid/data/ready     TX stream to host
//   io_rx_valid/data/ready     RX stream from host
//   io_buffer_full             registered TX near-full throttle
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int          ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter logic [31:0] IO_ADDR    = DEFAULT_IO_ADDR,
    parameter int          FIFO_DEPTH = 8,
    parameter int          FIFO_WIDTH = 3
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_tx_valid,
    output logic [7:0]  io_tx_data,
    input  logic        io_tx_ready,
    input  logic        io_rx_valid,
    input  logic [7:0]  io_rx_data,
    output logic        io_rx_ready,
    output logic        io_buffer_full
);

    localparam int CW = FIFO_WIDTH + 1;
    localparam logic [FIFO_WIDTH:0] BF_LEVEL = CW'(FIFO_DEPTH - 2);

    logic [7:0] ram [2**ADDR_WIDTH];

    logic        sel_data;
    logic        sel_stat;
    logic        cpu_rd;
    logic        cpu_wr;
    logic        tx_push;
    logic        tx_pop;
    logic        rx_pop;
    logic        rx_full;
    logic [7:0]  rx_byte;
    logic [7:0]  status;
    logic [FIFO_WIDTH:0] tx_count;
    logic [FIFO_WIDTH:0] tx_count_nxt;

    assign cpu_rd   = rdy_in && !mem_wr;
    assign cpu_wr   = rdy_in && mem_wr;
    assign sel_data = (mem_a == IO_ADDR);

`ifdef IO_STATUS_REG_EN
    logic overflow;

    assign sel_stat = (mem_a == IO_ADDR + STATUS_OFFSET);

    always_comb begin
        status            = '0;
        status[STAT_FULL] = io_buffer_full;
        status[STAT_RX]   = rx_full;
        status[STAT_OVF]  = overflow;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            overflow <= 1'b0;
        else if (cpu_wr && sel_stat)
            overflow <= 1'b0;
        else if (tx_push && (tx_count == CW'(FIFO_DEPTH)) && !tx_pop)
            overflow <= 1'b1;
    end
`else
    assign sel_stat = 1'b0;
    assign status   = '0;
`endif

    assign tx_push     = cpu_wr && sel_data;
    assign rx_pop      = cpu_rd && sel_data;
    assign io_tx_valid = (tx_count != '0);
    assign tx_pop      = io_tx_valid && io_tx_ready;
    assign io_rx_ready = !rx_full;

    io_tx_fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (FIFO_DEPTH),
        .PTR_WIDTH  (FIFO_WIDTH)
    ) u_tx_fifo (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .push      (tx_push),
        .push_data (mem_dout),
        .pop       (tx_pop),
        .count     (tx_count),
        .count_nxt (tx_count_nxt),
        .head_data (io_tx_data)
    );

    always_ff @(posedge clk_in) begin
        if (cpu_wr && !sel_data && !sel_stat)
            ram[mem_a[ADDR_WIDTH-1:0]] <= mem_dout;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            mem_din <= '0;
        end else if (cpu_rd) begin
            if (sel_data)
                mem_din <= rx_full ? rx_byte : 8'h00;
            else if (sel_stat)
                mem_din <= status;
            else
                mem_din <= ram[mem_a[ADDR_WIDTH-1:0]];
        end
    end

    // Capture is only possible when empty, so a same-cycle CPU pop returns 0
    // and the new byte is what remains held.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rx_full <= 1'b0;
            rx_byte <= '0;
        end else if (io_rx_valid && !rx_full) begin
            rx_full <= 1'b1;
            rx_byte <= io_rx_data;
        end else if (rx_pop) begin
            rx_full <= 1'b0;
        end
    end

    // Two slots of slack cover stores already in flight when the CPU stalls.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            io_buffer_full <= 1'b0;
        else
            io_buffer_full <= (tx_count_nxt >= BF_LEVEL);
    end

endmodule
